// File: rtl/tdm_pkg.sv
// Shared definitions for the 2-channel bit-interleaved TDM link,
// used by both the transmit and receive ends.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } tdm_state_e;

  // Sync marks frame bit 0, which carries the channel A MSB; even bits are A, odd bits are B.
  localparam int SYNC_BIT_INDEX = 0;

  function automatic int FRAME_BITS(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/tdm_shift_in.sv
// MSB-first serial-to-parallel shift register with synchronous clear.
// Exposes the next-state word so the caller can capture a word on its final bit.
module tdm_shift_in #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] base;

  // Clear and shift together start a fresh word with din as its first bit.
  always_comb begin
    base   = clr ? '0 : q;
    q_next = shift_en ? {base[WIDTH-2:0], din} : base;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q <= '0;
    else        q <= q_next;
  end

endmodule

// File: rtl/tdm_demux_1_2.sv
// Receive side of the 2-channel TDM link: aligns on the sync marker and
// de-interleaves the serial stream into channel A and B words.
//
// state | meaning
// HUNT  | waiting for an accepted bit with sync=1
// RUN   | aligned; k tracks the frame bit position
module tdm_demux_1_2
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] a_word,
  output logic [WIDTH-1:0] b_word,
  output logic             word_valid,
  output logic             frame_err,
  output logic             locked
);

  localparam int NBITS = FRAME_BITS(WIDTH);
  localparam int K_W   = $clog2(NBITS);
  localparam logic [K_W-1:0] K_START = K_W'(SYNC_BIT_INDEX);
  localparam logic [K_W-1:0] K_AFTER = K_W'(SYNC_BIT_INDEX + 1);
  localparam logic [K_W-1:0] K_LAST  = K_W'(NBITS - 1);

  tdm_state_e       state_q;
  logic [K_W-1:0]   k_q;
  logic             in_run;
  logic             sync_bit;
  logic             data_bit;
  logic             a_en;
  logic             b_en;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;

  assign in_run   = (state_q == RUN);
  assign sync_bit = din_valid && sync;
  // A data bit is anything accepted mid-frame without sync; k=0 without sync is a framing error.
  assign data_bit = din_valid && !sync && in_run && (k_q != K_START);
  assign a_en     = sync_bit || (data_bit && !k_q[0]);
  assign b_en     = data_bit && k_q[0];

  tdm_shift_in #(.WIDTH(WIDTH)) u_shift_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (sync_bit),
    .shift_en (a_en),
    .din      (din),
    .q_next   (a_next)
  );

  tdm_shift_in #(.WIDTH(WIDTH)) u_shift_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (sync_bit),
    .shift_en (b_en),
    .din      (din),
    .q_next   (b_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      k_q        <= K_START;
      a_word     <= '0;
      b_word     <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (sync_bit) begin
        // Sync anywhere but k=0 in RUN aborts the partial frame and realigns here.
        frame_err <= in_run && (k_q != K_START);
        k_q       <= K_AFTER;
        state_q   <= RUN;
        locked    <= 1'b1;
      end else if (din_valid && in_run) begin
        if (k_q == K_START) begin
          frame_err <= 1'b1;
          state_q   <= HUNT;
          locked    <= 1'b0;
        end else if (k_q == K_LAST) begin
          k_q        <= K_START;
          a_word     <= a_next;
          b_word     <= b_next;
          word_valid <= 1'b1;
        end else begin
          k_q <= k_q + 1'b1;
        end
      end
    end
  end

endmodule
